seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display bank. It holds a shadow copy of N hex nibbles, decimal points and per-digit blanks, and scans one digit at a time at a programmable rate, with a dead-time gap between digits to suppress ghosting. It sits between the debug/status register file and the board's segment and anode pins. It replaces the per-digit combinational decoders with a single shared font decode.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_font_rom.sv | 21 ++
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types and constants for the 7-segment scan driver:
//             the segment vector type, the hex font table and the
//             all-segments-off pattern.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  // Segment vector, a at index 0 through g at index 6; 0 = segment lit.
  typedef logic [0:6] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Common-anode hex font, indexed by nibble value, pattern abcdefg.
  localparam seg_t SEG7_FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

`default_nettype wire

// File: rtl/seg7_font_rom.sv
// ============================================================================
//  Module   : seg7_font_rom
//  Purpose  : Combinational hex-to-7-segment decode (common anode, 0 = lit).
//  Ports    : nib - 4-bit hex value in
//             seg - segments a..g out
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_font_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = SEG7_FONT[nib];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed driver for an N-digit common-anode 7-segment
//             bank. Holds a shadow copy of nibbles / decimal points / blanks
//             and scans one digit per slot of SCAN_DIV cycles, keeping the
//             anode off for the first DEAD_CYCLES cycles of every slot.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_load, i_data[4N], i_dp[N], i_blank[N]  - shadow update
//             o_seg[0:6], o_dp, o_an[N]                - pins, active low
//             o_frame                                  - one pulse per scan
//  Config   : SEG7_LZB_EN - when defined, leading zeros (nibble 0, dp 0,
//             with all higher digits also zero) are blanked; digit 0 never.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  output logic [0:6]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;

  logic                    slot_end;
  logic [IDX_W-1:0]        next_idx;
  logic [4*NUM_DIGITS-1:0] src_data;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_blank;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    lz_blank;
  seg_t                    font_seg;

  assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));

  // With a single digit the compare is always true, so idx stays at 0.
  always_comb begin
    next_idx = idx + IDX_W'(1);
    if (idx == IDX_W'(NUM_DIGITS - 1)) next_idx = '0;
  end

  // A load landing on the slot boundary bypasses the shadow so the new
  // digit never shows a stale value for a whole slot.
  assign src_data  = i_load ? i_data  : sh_data;
  assign src_dp    = i_load ? i_dp    : sh_dp;
  assign src_blank = i_load ? i_blank : sh_blank;

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == next_idx) begin
        sel_nib   = src_data[4*k +: 4];
        sel_dp    = src_dp[k];
        sel_blank = src_blank[k];
      end
    end
  end

`ifdef SEG7_LZB_EN
  // Walk from the most significant digit down; a digit is a leading zero
  // if it and every digit above it hold nibble 0 with dp off.
  logic all_zero;
  always_comb begin
    all_zero = 1'b1;
    lz_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (src_data[4*k +: 4] == 4'h0) && !src_dp[k];
      if (IDX_W'(k) == next_idx) lz_blank = all_zero && (k != 0);
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      cnt       <= '0;
      idx       <= '0;
      cur_nib   <= 4'h0;
      cur_dp    <= 1'b0;
      cur_blank <= 1'b1;
    end else begin
      if (i_load) begin
        sh_data  <= i_data;
        sh_dp    <= i_dp;
        sh_blank <= i_blank;
      end
      if (slot_end) begin
        cnt       <= '0;
        idx       <= next_idx;
        cur_nib   <= sel_nib;
        cur_dp    <= sel_dp;
        cur_blank <= sel_blank | lz_blank;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  seg7_font_rom u_font (
    .nib (cur_nib),
    .seg (font_seg)
  );

  // Outputs decode registered state only.
  always_comb begin
    o_seg = cur_blank ? SEG_OFF : font_seg;
    o_dp  = cur_blank ? 1'b1 : ~cur_dp;
    o_an  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IDX_W'(k) == idx) && (cnt >= CNT_W'(DEAD_CYCLES)) && !cur_blank)
        o_an[k] = 1'b0;
    end
  end

  assign o_frame = (idx == '0) && (cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Directed self-checking bench for seg7_scan_driver with
//             NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [0:6]  seg;
  logic        odp;
  logic [3:0]  an;
  logic        frame;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (8),
    .DEAD_CYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (load),
    .i_data  (data),
    .i_dp    (dp),
    .i_blank (blank),
    .o_seg   (seg),
    .o_dp    (odp),
    .o_an    (an),
    .o_frame (frame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Advance on falling edges; cyc counts rising edges since reset release.
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [6:0] scan_seg [4] = '{7'b0111000, 7'b0000110, 7'b0001000, 7'b1001111};
  logic       scan_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [3:0] exp_an;
    int d, k;

    // Reset held low
    @(negedge clk);
    check("rst_seg", seg, 7'b1111111);
    check("rst_an", an, 4'hF);
    check("rst_dp", odp, 1'b1);
    check("rst_frame", frame, 1'b1);

    // Release with a load on the first cycle
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    load  = 1'b1;
    data  = 16'h1A3F;
    dp    = 4'b0100;
    blank = 4'b0000;
    #1;
    check("rel_frame", frame, 1'b1);
    check("rel_an", an, 4'hF);
    go_to(1);
    load = 1'b0;
    check("frame_low", frame, 1'b0);

    // Full frame of scanning
    for (int c = 8; c < 40; c++) begin
      go_to(c);
      d = (c / 8) % 4;
      k = c % 8;
      exp_an = 4'hF;
      if (k >= 2) exp_an[d] = 1'b0;
      check("scan_seg", seg, scan_seg[d]);
      check("scan_dp", odp, scan_dp[d]);
      check("scan_an", an, exp_an);
      check("scan_frame", frame, (c % 32) == 0);
    end

    // Mid-slot load while digit 1 shows 3
    go_to(44);
    check("mid_pre", seg, 7'b0000110);
    load = 1'b1;
    data = 16'h0000;
    dp   = 4'b0000;
    go_to(45);
    load = 1'b0;
    for (int c = 45; c < 48; c++) begin
      go_to(c);
      check("mid_seg", seg, 7'b0000110);
      check("mid_an", an, 4'b1101);
    end
    go_to(48);
    check("mid_next_seg", seg, 7'b0000001);
    check("mid_next_dp", odp, 1'b1);
    go_to(50);
    check("mid_next_an", an, 4'b1011);

    // Load on the edge that ends the slot
    go_to(55);
    check("bnd_pre", seg, 7'b0000001);
    load = 1'b1;
    data = 16'h8000;
    dp   = 4'b1000;
    go_to(56);
    load = 1'b0;
    check("bnd_seg", seg, 7'b0000000);
    check("bnd_dp", odp, 1'b0);
    check("bnd_dead_an", an, 4'hF);
    go_to(58);
    check("bnd_an", an, 4'b0111);

    // Blank digit 3
    go_to(60);
    load  = 1'b1;
    data  = 16'h8000;
    dp    = 4'b0000;
    blank = 4'b1000;
    go_to(61);
    load = 1'b0;
    check("blk_cur_seg", seg, 7'b0000000);
    check("blk_cur_an", an, 4'b0111);
    go_to(66);
    check("blk_d0_seg", seg, 7'b0000001);
    check("blk_d0_an", an, 4'b1110);
    for (int c = 88; c < 96; c++) begin
      go_to(c);
      check("blk_an", an, 4'hF);
      check("blk_seg", seg, 7'b1111111);
      check("blk_dp", odp, 1'b1);
    end

    // Asynchronous reset mid-slot
    go_to(98);
    check("pre_arst_an", an, 4'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", seg, 7'b1111111);
    check("arst_an", an, 4'hF);
    check("arst_dp", odp, 1'b1);
    check("arst_frame", frame, 1'b1);

    // Restart and leading-zero behaviour
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    load  = 1'b1;
    data  = 16'h0050;
    dp    = 4'b0000;
    blank = 4'b0000;
    go_to(1);
    load = 1'b0;
    go_to(12);
    check("lz_d1_seg", seg, 7'b0100100);
    check("lz_d1_an", an, 4'b1101);
`ifdef SEG7_LZB_EN
    go_to(20);
    check("lz_d2_an", an, 4'hF);
    check("lz_d2_seg", seg, 7'b1111111);
    go_to(28);
    check("lz_d3_an", an, 4'hF);
    check("lz_d3_seg", seg, 7'b1111111);
`else
    go_to(20);
    check("nolz_d2_an", an, 4'b1011);
    check("nolz_d2_seg", seg, 7'b0000001);
    go_to(28);
    check("nolz_d3_an", an, 4'b0111);
    check("nolz_d3_seg", seg, 7'b0000001);
`endif
    go_to(36);
    check("lz_d0_seg", seg, 7'b0000001);
    check("lz_d0_an", an, 4'b1110);
    load = 1'b1;
    data = 16'h0000;
    go_to(37);
    load = 1'b0;
`ifdef SEG7_LZB_EN
    go_to(44);
    check("lz0_d1_an", an, 4'hF);
    go_to(52);
    check("lz0_d2_an", an, 4'hF);
    go_to(60);
    check("lz0_d3_an", an, 4'hF);
`else
    go_to(44);
    check("nolz0_d1_an", an, 4'b1101);
    check("nolz0_d1_seg", seg, 7'b0000001);
    go_to(60);
    check("nolz0_d3_an", an, 4'b0111);
`endif
    go_to(68);
    check("lz0_d0_an", an, 4'b1110);
    check("lz0_d0_seg", seg, 7'b0000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
